// File: rtl/mult8_sequencer.sv
// Sequential 8x8 unsigned multiplier built from four passes through a shared
// combinational 4x4 multiplier, with valid/ready handshakes on both sides.
module mult8_sequencer #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         op_a,
    input  logic [7:0]         op_b,
    output logic [3:0]         mul_x,
    output logic [3:0]         mul_y,
    input  logic [7:0]         mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        product,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [7:0]   a_reg;
    logic [7:0]   b_reg;
    logic [15:0]  acc;
    logic [1:0]   step;
    logic [15:0]  partial;

    // Nibble selection and partial-product alignment for the current step.
    // Driven only from registered state, so no input reaches an output combinationally.
    always_comb begin
        mul_x   = 4'h0;
        mul_y   = 4'h0;
        partial = 16'h0000;
        if (state == CALC) begin
            case (step)
                2'd0: begin
                    mul_x   = a_reg[3:0];
                    mul_y   = b_reg[3:0];
                    partial = {8'h00, mul_p};
                end
                2'd1: begin
                    mul_x   = a_reg[3:0];
                    mul_y   = b_reg[7:4];
                    partial = {4'h0, mul_p, 4'h0};
                end
                2'd2: begin
                    mul_x   = a_reg[7:4];
                    mul_y   = b_reg[3:0];
                    partial = {4'h0, mul_p, 4'h0};
                end
                default: begin
                    mul_x   = a_reg[7:4];
                    mul_y   = b_reg[7:4];
                    partial = {mul_p, 8'h00};
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= 8'h00;
            b_reg    <= 8'h00;
            acc      <= 16'h0000;
            step     <= 2'd0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        acc   <= 16'h0000;
                        step  <= 2'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Max result 0xFE01 fits in 16 bits, so the carry-out is dropped.
                    acc  <= acc + partial;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state    <= IDLE;
                        op_count <= op_count + COUNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    // acc holds its value through IDLE, so the last product stays visible until the next accept.
    assign product   = acc;

endmodule

// File: tb/tb_mult8_sequencer.sv
// Directed and randomized checks of mult8_sequencer against hand-computed
// products, using a behavioral 4x4 multiplier on the shared-multiplier port.
module tb_mult8_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;
    logic [7:0]  op_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_count = 8'h00;

    mult8_sequencer #(.COUNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .op_count  (op_count)
    );

    assign mul_p = {4'h0, mul_x} * {4'h0, mul_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation from IDLE (called between edges); returns the product seen
    // when out_valid first rose and the number of edges from accept to out_valid.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                          output logic [15:0] prod, output int lat, output logic ok);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk); #1;
        in_valid = 1'($urandom_range(0, 1));
        op_a     = 8'($urandom);
        op_b     = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        ok   = out_valid;
        prod = product;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (ok) exp_count = exp_count + 8'd1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({in_ready, out_valid, busy, product, mul_x, mul_y, op_count} !==
            {1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b prod=%h x=%h y=%h cnt=%h expected 1 0 0 0000 0 0 00",
                     in_ready, out_valid, busy, product, mul_x, mul_y, op_count);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [3:0]  exp_x   [4] = '{4'h2, 4'h2, 4'h1, 4'h1};
        logic [3:0]  exp_y   [4] = '{4'h4, 4'h3, 4'h4, 4'h3};
        logic [15:0] exp_acc [4] = '{16'h0008, 16'h0068, 16'h00A8, 16'h03A8};
        in_valid  = 1'b1;
        op_a      = 8'h12;
        op_b      = 8'h34;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({mul_x, mul_y, out_valid, busy, in_ready} !== {exp_x[i], exp_y[i], 1'b0, 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL basic_step%0d: got x=%h y=%h vld=%b busy=%b rdy=%b expected x=%h y=%h 0 1 0",
                         i, mul_x, mul_y, out_valid, busy, in_ready, exp_x[i], exp_y[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (product !== exp_acc[i]) begin
                n_errors++;
                $display("FAIL basic_acc%0d: got %h expected %h", i, product, exp_acc[i]);
            end
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_latency: got out_valid=%b expected 1 after 4 edges", out_valid);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        n_checks++;
        if ({op_count, in_ready, out_valid, mul_x, mul_y, product} !==
            {exp_count, 1'b1, 1'b0, 4'h0, 4'h0, 16'h03A8}) begin
            n_errors++;
            $display("FAIL basic_handshake: got cnt=%h rdy=%b vld=%b x=%h y=%h prod=%h expected %h 1 0 0 0 03a8",
                     op_count, in_ready, out_valid, mul_x, mul_y, product, exp_count);
        end
        $display("test_basic: 0x12*0x34 product=%h", product);
    endtask

    task automatic test_corners();
        logic [7:0]  ta  [2] = '{8'hFF, 8'h00};
        logic [7:0]  tb  [2] = '{8'hFF, 8'hA5};
        logic [15:0] te  [2] = '{16'hFE01, 16'h0000};
        logic [15:0] prod;
        int          lat;
        logic        ok;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], tb[i], 0, prod, lat, ok);
            n_checks++;
            if (!ok || prod !== te[i] || lat != 4 || op_count !== exp_count) begin
                n_errors++;
                $display("FAIL corner_%h_%h: got prod=%h lat=%0d cnt=%h expected %h 4 %h",
                         ta[i], tb[i], prod, lat, op_count, te[i], exp_count);
            end
            $display("test_corners: %h*%h product=%h latency=%0d", ta[i], tb[i], prod, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        in_valid = 1'b1;
        op_a     = 8'h5A;
        op_b     = 8'hC3;
        @(posedge clk); #1;
        op_a = 8'h11;
        op_b = 8'h22;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != 4) begin
            n_errors++;
            $display("FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, product, in_ready, busy} !== {1'b1, 16'h448E, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL bp_hold%0d: got vld=%b prod=%h rdy=%b busy=%b expected 1 448e 0 1",
                         i, out_valid, product, in_ready, busy);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_count = exp_count + 8'd1;
        n_checks++;
        if ({out_valid, in_ready, busy, op_count} !== {1'b0, 1'b1, 1'b0, exp_count}) begin
            n_errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b cnt=%h expected 0 1 0 %h",
                     out_valid, in_ready, busy, op_count, exp_count);
        end
        $display("test_backpressure: 0x5A*0xC3 held 3 cycles, product=%h", product);
    endtask

    task automatic test_reset_abort();
        logic [15:0] prod;
        int          lat;
        logic        ok;
        in_valid = 1'b1;
        op_a     = 8'h12;
        op_b     = 8'h34;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if ({mul_x, mul_y} !== {4'h1, 4'h4}) begin
            n_errors++;
            $display("FAIL abort_step2: got x=%h y=%h expected 1 4", mul_x, mul_y);
        end
        rst = 1'b1;
        #1;
        exp_count = 8'h00;
        n_checks++;
        if ({in_ready, out_valid, busy, product, mul_x, mul_y, op_count} !==
            {1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 8'h00}) begin
            n_errors++;
            $display("FAIL abort_outputs: got rdy=%b vld=%b busy=%b prod=%h x=%h y=%h cnt=%h expected 1 0 0 0000 0 0 00",
                     in_ready, out_valid, busy, product, mul_x, mul_y, op_count);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h03, 8'h05, 0, prod, lat, ok);
        n_checks++;
        if (!ok || prod !== 16'h000F || op_count !== 8'h01) begin
            n_errors++;
            $display("FAIL abort_next_op: got prod=%h cnt=%h expected 000f 01", prod, op_count);
        end
        $display("test_reset_abort: next op 0x03*0x05 product=%h count=%h", prod, op_count);
    endtask

    task automatic test_back_to_back();
        logic [15:0] prod;
        int          lat;
        logic        ok;
        logic [7:0]  a;
        logic [7:0]  b;
        int          bad = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 8'h00;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            b = 8'(255 - i) ^ 8'h5C;
            run_op(a, b, 0, prod, lat, ok);
            n_checks++;
            if (!ok || prod !== 16'(a) * 16'(b) || lat != 4) begin
                n_errors++;
                bad++;
                $display("FAIL b2b_%0d: got prod=%h lat=%0d expected %h 4", i, prod, lat, 16'(a) * 16'(b));
            end
        end
        n_checks++;
        if (op_count !== 8'h00) begin
            n_errors++;
            $display("FAIL b2b_wrap: got op_count=%h expected 00", op_count);
        end
        $display("test_back_to_back: 256 ops, %0d bad, op_count=%h", bad, op_count);
    endtask

    task automatic test_random();
        logic [15:0] prod;
        int          lat;
        logic        ok;
        logic [7:0]  a;
        logic [7:0]  b;
        int          bad = 0;
        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(a, b, $urandom_range(0, 3), prod, lat, ok);
            n_checks++;
            if (!ok || prod !== 16'(a) * 16'(b) || lat != 4 || op_count !== exp_count) begin
                n_errors++;
                bad++;
                $display("FAIL rand_%0d: got %h*%h=%h lat=%0d cnt=%h expected %h 4 %h",
                         i, a, b, prod, lat, op_count, 16'(a) * 16'(b), exp_count);
            end
        end
        $display("test_random: 2000 ops, %0d bad, op_count=%h", bad, op_count);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
